mips_mem_arbiter: RTL and testbench

Shares one single-port unified instruction/data memory between the pipeline's instruction-fetch (IF) port and its load/store (MEM-stage) data port. Each side uses a request/acknowledge handshake. The arbiter picks one requester per access and sequences the memory through issue, wait-state and response phases. Data accesses have priority over fetch, and a starvation counter guarantees fetch progress.

---
 rtl/mips_mem_arbiter.sv | 90 +++++++++
 tb/tb_mips_mem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-port I/D memory between fetch and data ports,
// data first, with a starvation bound that guarantees fetch progress.
module mips_mem_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t     state;
    logic [3:0] wait_cnt;
    logic [3:0] starve_cnt;
    logic       store;
    logic       grant_d;
    // fetch only wins a contested cycle once data has starved it STARVE_MAX times
    assign grant_d = dm_req && !(if_req && starve_cnt == 4'(STARVE_MAX));
    assign busy    = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            owner      <= 1'b0;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            store      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (if_req || dm_req) begin
                    state      <= ISSUE;
                    owner      <= grant_d;
                    mem_en     <= 1'b1;
                    mem_we     <= grant_d && dm_we;
                    store      <= grant_d && dm_we;
                    mem_addr   <= grant_d ? dm_addr : if_addr;
                    if (grant_d) mem_wdata <= dm_wdata;
                    starve_cnt <= (grant_d && if_req) ?
                                  starve_cnt + 4'(starve_cnt != 4'(STARVE_MAX)) : '0;
                end
                ISSUE: begin
                    mem_en   <= 1'b0;
                    mem_we   <= 1'b0;
                    wait_cnt <= 4'(WAIT_CYCLES);
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state  <= RESP;
                        if_ack <= !owner;
                        dm_ack <= owner;
                        if (!store && owner) dm_rdata <= mem_rdata;
                        if (!store && !owner) if_rdata <= mem_rdata;
                    end
                end
                default: begin
                    if_ack <= 1'b0;
                    dm_ack <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: three arbiters (WAIT_CYCLES 1/3/15) exercised in turn against a
// transaction-level model of arbitration, timing and memory contents.
module tb_mips_mem_arbiter;
    localparam int SM = 4;
    logic clk = 0;
    logic rst_n = 0, init_req = 0, go = 0;
    logic if_req = 0, dm_req = 0, dm_we = 0;
    logic [9:0] if_addr = 0, dm_addr = 0;
    logic [31:0] dm_wdata = 0;
    logic if_ack [3], dm_ack [3], mem_en [3], mem_we [3], owner [3], busy [3];
    logic [31:0] if_rdata [3], dm_rdata [3], mem_wdata [3];
    logic [9:0] mem_addr [3];
    int act = 0, checks = 0, failures = 0;
    always #5 clk = ~clk;

    function automatic int wsel(int i);
        return i == 0 ? 1 : i == 1 ? 3 : 15;
    endfunction
    function automatic logic [31:0] init_val(int a);
        return a == 5 ? 32'h2862000A : 32'(a) * 32'h9E3779B1 + 32'h01234567;
    endfunction
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s W=%0d t=%0t got=%h exp=%h", name, wsel(act), $time, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : inst
        logic [31:0] bmem [1024];
        logic [31:0] rdata;
        logic [9:0]  rd_addr = 0;
        int          rd_cnt = 0;
        mips_mem_arbiter #(.WAIT_CYCLES(g == 0 ? 1 : g == 1 ? 3 : 15), .STARVE_MAX(SM)) dut (
            .clk(clk), .rst_n(rst_n),
            .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
            .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
            .dm_ack(dm_ack[g]), .dm_rdata(dm_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(rdata),
            .owner(owner[g]), .busy(busy[g])
        );
        // read data is only genuine in the one cycle it is promised; otherwise inverted
        always @(posedge clk) begin
            if (init_req) begin
                for (int a = 0; a < 1024; a++) bmem[a] <= init_val(a);
                rd_cnt <= 0;
            end else if (mem_en[g]) begin
                if (mem_we[g]) bmem[mem_addr[g]] <= mem_wdata[g];
                rd_addr <= mem_addr[g];
                rd_cnt  <= wsel(g);
            end else if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
        end
        assign rdata = rd_cnt == 1 ? bmem[rd_addr] : ~bmem[rd_addr];
    end

    // transaction model: a grant at the end of IDLE cycle t0 issues at t0+1,
    // acks at t0+2+W and frees the arbiter for sampling at t0+3+W
    logic [31:0] ref_mem [1024];
    int c = 0, t0 = 0, starve = 0;
    logic act_v = 0, g_d = 0, g_we = 0, d_pick;
    logic [9:0] g_addr = 0;
    logic [31:0] g_wdata = 0, e_ifrd = 0, e_dmrd = 0;
    assign d_pick = dm_req && !(if_req && starve == SM);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (init_req) for (int a = 0; a < 1024; a++) ref_mem[a] <= init_val(a);
            act_v <= 0; starve <= 0; g_d <= 0; g_addr <= 0; e_ifrd <= 0; e_dmrd <= 0;
        end else begin
            c <= c + 1;
            if ((!act_v || c >= t0 + 3 + wsel(act)) && (if_req || dm_req)) begin
                act_v   <= 1;
                t0      <= c;
                g_d     <= d_pick;
                g_we    <= d_pick && dm_we;
                g_addr  <= d_pick ? dm_addr : if_addr;
                g_wdata <= dm_wdata;
                starve  <= (d_pick && if_req) ? (starve < SM ? starve + 1 : SM) : 0;
            end
            if (act_v && c == t0 + 1 && g_we) ref_mem[g_addr] <= g_wdata;
            if (act_v && c == t0 + 1 + wsel(act) && !g_we) begin
                if (g_d) e_dmrd <= ref_mem[g_addr];
                else e_ifrd <= ref_mem[g_addr];
            end
        end
    end

    always @(negedge clk) if (go) begin
        int w;
        logic e_en, e_ack, e_busy;
        w = wsel(act);
        e_en   = act_v && c == t0 + 1;
        e_ack  = act_v && c == t0 + 2 + w;
        e_busy = act_v && c > t0 && c <= t0 + 2 + w;
        chk("busy", 32'(busy[act]), 32'(e_busy));
        chk("mem_en", 32'(mem_en[act]), 32'(e_en));
        chk("mem_we", 32'(mem_we[act]), 32'(e_en && g_we));
        chk("if_ack", 32'(if_ack[act]), 32'(e_ack && !g_d));
        chk("dm_ack", 32'(dm_ack[act]), 32'(e_ack && g_d));
        chk("owner", 32'(owner[act]), 32'(g_d));
        chk("mem_addr", 32'(mem_addr[act]), 32'(g_addr));
        chk("if_rdata", if_rdata[act], e_ifrd);
        chk("dm_rdata", dm_rdata[act], e_dmrd);
        if (e_en && g_we) chk("mem_wdata", mem_wdata[act], g_wdata);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic wait_ack(output int n, output logic d);
        n = 0;
        do begin
            tick();
            n++;
            if (n == 2) begin
                if_addr = ~if_addr;
                dm_addr = ~dm_addr;
            end
        end while (!(if_ack[act] || dm_ack[act]) && n < 40);
        d = dm_ack[act];
        if (n >= 40) chk("ack_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int n;
        logic d;
        logic [9:0] order;
        for (int i = 0; i < 3; i++) begin
            act = i;
            rst_n = 0; init_req = 1; if_req = 0; dm_req = 0; dm_we = 0;
            tick(); tick();
            init_req = 0; go = 1;
            chk("rst_busy", 32'(busy[i]), 32'd0);
            chk("rst_owner", 32'(owner[i]), 32'd0);
            chk("rst_mem_en", 32'(mem_en[i]), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr[i]), 32'd0);
            chk("rst_if_rdata", if_rdata[i], 32'd0);
            chk("rst_dm_rdata", dm_rdata[i], 32'd0);
            rst_n = 1;
            tick();
            if_req = 1; if_addr = 5;
            wait_ack(n, d);
            if_req = 0;
            chk("fetch_lat", 32'(n), 32'(2 + wsel(i)));
            chk("fetch_port", 32'(d), 32'd0);
            chk("fetch_data", if_rdata[i], 32'h2862000A);
            tick();
            dm_req = 1; dm_we = 1; dm_addr = 100; dm_wdata = 32'hDEADBEEF;
            wait_ack(n, d);
            chk("store_port", 32'(d), 32'd1);
            dm_we = 0; dm_addr = 100;
            wait_ack(n, d);
            dm_req = 0;
            chk("load_lat", 32'(n), 32'(3 + wsel(i)));
            chk("load_data", dm_rdata[i], 32'hDEADBEEF);
            tick();
            if_req = 1; dm_req = 1; if_addr = 20; dm_addr = 40; order = 0;
            for (int k = 0; k < 10; k++) begin
                wait_ack(n, d);
                order = {order[8:0], d};
            end
            if_req = 0; dm_req = 0;
            chk("grant_order", 32'(order), 32'(10'b1111011110));
            tick();
            if_req = 1; if_addr = 9;
            tick(); tick();
            rst_n = 0;
            #1;
            chk("rst_async_busy", 32'(busy[i]), 32'd0);
            chk("rst_async_ack", 32'(if_ack[i]), 32'd0);
            if_req = 0;
            tick(); tick();
            rst_n = 1;
            tick();
            if_req = 1; if_addr = 9;
            wait_ack(n, d);
            if_req = 0;
            chk("retry_lat", 32'(n), 32'(2 + wsel(i)));
            chk("retry_data", if_rdata[i], init_val(9));
            for (int k = 0; k < 400; k++) begin
                tick();
                if (if_ack[i]) if_req = $urandom_range(0, 1) == 1;
                else if (!if_req) if_req = $urandom_range(0, 3) == 0;
                else if ($urandom_range(0, 31) == 0) if_req = 0;
                if ($urandom_range(0, 3) == 0) if_addr = 10'($urandom);
                if (dm_ack[i]) dm_req = $urandom_range(0, 1) == 1;
                else if (!dm_req) dm_req = $urandom_range(0, 2) == 0;
                else if ($urandom_range(0, 31) == 0) dm_req = 0;
                if ($urandom_range(0, 3) == 0) begin
                    dm_addr  = 10'($urandom_range(96, 111));
                    dm_we    = $urandom_range(0, 1) == 1;
                    dm_wdata = $urandom;
                end
            end
            if_req = 0; dm_req = 0;
            repeat (25) tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
